approx_err_sweep: RTL and testbench
===================================

APPROX_ERR_SWEEP -- requirements
Module: approx_err_sweep

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits (2..12).
REQ-002 SHALL have parameter T, default 2, number of truncated operand LSBs (0..W-1).
REQ-003 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-004 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have: start  input  1  begin sweep, sampled in IDLE only.
REQ-006 SHALL have: mode  input  2  00 exact, 01 truncate a, 10 truncate a and b, 11 exact.
REQ-007 SHALL have: busy  output  1  high in RUN and DRAIN.
REQ-008 SHALL have: done  output  1  one-cycle pulse at sweep end.
REQ-009 SHALL have: err_cnt  output  2W+1  pairs with approx != exact.
REQ-010 SHALL have: err_sum  output  4W  sum of |exact - approx|.
REQ-011 SHALL have: err_max  output  2W  largest |exact - approx|.
REQ-012 SHALL have: res_valid  output  1, res_ready  input  1, res_a  output  W, res_b  output  W, res_approx  output  2W, res_exact  output  2W  per-pair result stream.

Function
REQ-013 SHALL use FSM IDLE -> RUN on start; RUN -> DRAIN after last pair issued; DRAIN -> DONE when pipeline empty; DONE -> IDLE unconditionally.
REQ-014 SHALL latch mode and clear err_cnt/err_sum/err_max on the start cycle; mode changes mid-sweep ignored.
REQ-015 SHALL issue every pair exactly once, a outer, b inner: (0,0),(0,1)..(0,2^W-1),(1,0)..(2^W-1,2^W-1); one pair per unstalled RUN cycle.
REQ-016 SHALL compute approx: mode 01 = ((a>>T)<<T)*b; mode 10 = ((a>>T)<<T)*((b>>T)<<T); modes 00/11 = a*b; exact always a*b, unsigned, 2W bits.
REQ-017 SHALL pipeline: stage 1 registers operands, stage 2 registers approx/exact, stage 3 updates accumulators and presents result stream; pair-to-accumulate latency 2 cycles.
REQ-018 SHALL hold res_* stable while res_valid && !res_ready and stall the whole pipeline and pair counter; transfer on res_valid && res_ready.
REQ-019 SHALL, with res_ready held 1, assert done exactly 2^(2W)+3 cycles after the start-sampling edge.
REQ-020 SHALL hold err_* after done until next start; start while busy or during DONE ignored.
REQ-021 SHALL not overflow: err_cnt max 2^(2W), err_sum max < 2^(4W); pair counter wrap to 0 ends issue.

Reset
REQ-022 SHALL on rst_n low, immediately: state IDLE, busy/done/res_valid 0, err_cnt/err_sum/err_max 0, res_a/res_b/res_approx/res_exact 0, pair counter 0.
REQ-023 SHALL abort any sweep on reset mid-operation with no partial results retained.

Configuration
REQ-024 SHALL with APPROX_STREAM_EN defined implement the result stream and backpressure per REQ-018.
REQ-025 SHALL without APPROX_STREAM_EN tie res_valid/res_a/res_b/res_approx/res_exact to 0, ignore res_ready, never stall; accumulators and done timing unchanged.

Structure
REQ-026 SHALL place mode encoding constants, FSM state typedef and accumulator-width constant functions in shared package approx_pkg.
REQ-027 SHALL instantiate one combinational sub-module approx_mul (params W, T; inputs a, b, mode; outputs approx, exact).

Verification
REQ-028 W=4,T=1, mode 00, res_ready=1 -> done at cycle 259 after start, err_cnt=0, err_sum=0, err_max=0.
REQ-029 W=4,T=1, mode 01 full sweep -> err_cnt=120, err_sum=960, err_max=15.
REQ-030 W=4,T=1, mode 10, stream pair a=3,b=3 -> res_approx=4, res_exact=9; a=2,b=2 -> 4, 4.
REQ-031 W=4,T=1, mode 01, res_ready low 10 cycles at pair (5,7) -> res_* held (5,7,28,35), final totals as REQ-029, done delayed 10 cycles.
REQ-032 rst_n pulsed low mid-RUN -> all outputs 0 same cycle; new start gives totals identical to clean sweep.
REQ-033 start pulsed during RUN and mode toggled mid-sweep -> no restart, totals match latched mode.

Source files
------------

// File: rtl/approx_pkg.sv
// approx_pkg: shared definitions for the approximate-multiplier error sweep.
// Contents:
//   MODE_*     operand-truncation mode encodings.
//   state_t    sweep controller states.
//   cnt_width  width of the mismatch counter for operand width w.
//   sum_width  width of the absolute-error accumulator for operand width w.
package approx_pkg;

  localparam logic [1:0] MODE_EXACT     = 2'b00;
  localparam logic [1:0] MODE_TRUNC_A   = 2'b01;
  localparam logic [1:0] MODE_TRUNC_AB  = 2'b10;
  localparam logic [1:0] MODE_EXACT_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter must reach 2^(2w), so it needs one bit more than a pair index.
  function automatic int cnt_width(input int w);
    return 2 * w + 1;
  endfunction

  // 2^(2w) pairs times an error below 2^(2w) stays below 2^(4w).
  function automatic int sum_width(input int w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/approx_err_sweep_if.sv
// approx_err_sweep_if: per-pair result stream of the error sweep.
// Signals:
//   res_valid   result present (master -> slave)
//   res_ready   consumer accepts result (slave -> master)
//   res_a/res_b operand pair, W bits each
//   res_approx  approximate product, 2W bits
//   res_exact   exact product, 2W bits
// Modports: master (producer, the sweep), slave (consumer).
interface approx_err_sweep_if #(
  parameter int W = 8
) ();
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_a;
  logic [W-1:0]   res_b;
  logic [2*W-1:0] res_approx;
  logic [2*W-1:0] res_exact;

  modport master (
    output res_valid, res_a, res_b, res_approx, res_exact,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_a, res_b, res_approx, res_exact,
    output res_ready
  );
endinterface

// File: rtl/approx_mul.sv
// approx_mul: combinational exact and approximate unsigned multiplier.
// Ports:
//   a, b    input  W    operands
//   mode    input  2    01 truncate a, 10 truncate a and b, 00/11 exact
//   approx  output 2W   product with the low T operand bits cleared per mode
//   exact   output 2W   a*b
module approx_mul
  import approx_pkg::*;
#(
  parameter int W = 8,
  parameter int T = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     mode,
  output logic [2*W-1:0] approx,
  output logic [2*W-1:0] exact
);

  logic [W-1:0]   a_trunc;
  logic [W-1:0]   b_trunc;
  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] a_trunc_ext;
  logic [2*W-1:0] b_trunc_ext;

  assign a_trunc     = (a >> T) << T;
  assign b_trunc     = (b >> T) << T;
  assign a_ext       = {{W{1'b0}}, a};
  assign b_ext       = {{W{1'b0}}, b};
  assign a_trunc_ext = {{W{1'b0}}, a_trunc};
  assign b_trunc_ext = {{W{1'b0}}, b_trunc};

  assign exact = a_ext * b_ext;

  always_comb begin
    approx = a_ext * b_ext;
    case (mode)
      MODE_TRUNC_A:               approx = a_trunc_ext * b_ext;
      MODE_TRUNC_AB:              approx = a_trunc_ext * b_trunc_ext;
      MODE_EXACT, MODE_EXACT_ALT: approx = a_ext * b_ext;
      default:                    approx = a_ext * b_ext;
    endcase
  end

endmodule

// File: rtl/approx_err_sweep.sv
// approx_err_sweep: sweeps every (a,b) operand pair through approx_mul and
// accumulates mismatch count, total and maximum absolute error.
// Build option: define APPROX_STREAM_EN to present each pair's result on the
// res stream with backpressure; otherwise the stream is tied off and the
// sweep never stalls.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start, mode    sweep request and multiplier mode (sampled in IDLE)
//   busy, done     high in RUN/DRAIN; one-cycle end-of-sweep pulse
//   err_cnt/err_sum/err_max  sweep statistics, held until next start
//   res            result stream (master side)
module approx_err_sweep
  import approx_pkg::*;
#(
  parameter int W = 8,
  parameter int T = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    done,
  output logic [cnt_width(W)-1:0] err_cnt,
  output logic [sum_width(W)-1:0] err_sum,
  output logic [2*W-1:0]          err_max,
  approx_err_sweep_if.master      res
);

  localparam int CNT_W = cnt_width(W);
  localparam int SUM_W = sum_width(W);

  state_t         state_reg, state_next;
  logic [2*W-1:0] pair_cnt_reg;
  logic [1:0]     mode_reg;
  logic           s1_valid_reg, s2_valid_reg;
  logic [W-1:0]   s1_a_reg, s1_b_reg, s2_a_reg, s2_b_reg;
  logic [2*W-1:0] s2_approx_reg, s2_exact_reg;
  logic [2*W-1:0] mul_approx, mul_exact, diff;
  logic           stall, issue, start_take, pipe_empty;

  approx_mul #(.W(W), .T(T)) u_mul (
    .a      (s1_a_reg),
    .b      (s1_b_reg),
    .mode   (mode_reg),
    .approx (mul_approx),
    .exact  (mul_exact)
  );

  assign start_take = (state_reg == ST_IDLE) && start;
  assign issue      = (state_reg == ST_RUN) && !stall;
  // An undelivered result counts as pipeline content.
  assign pipe_empty = !s1_valid_reg && !s2_valid_reg && !stall;
  assign diff       = (s2_exact_reg >= s2_approx_reg) ? (s2_exact_reg - s2_approx_reg)
                                                      : (s2_approx_reg - s2_exact_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        // The all-ones pair is the last; the counter wraps to 0 as it issues.
        if (!stall && (pair_cnt_reg == {(2*W){1'b1}})) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pair counter, operand/product pipeline and accumulators all freeze together on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt_reg  <= '0;
      mode_reg      <= MODE_EXACT;
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s2_valid_reg  <= 1'b0;
      s2_a_reg      <= '0;
      s2_b_reg      <= '0;
      s2_approx_reg <= '0;
      s2_exact_reg  <= '0;
      err_cnt       <= '0;
      err_sum       <= '0;
      err_max       <= '0;
    end else if (start_take) begin
      mode_reg     <= mode;
      pair_cnt_reg <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      err_cnt      <= '0;
      err_sum      <= '0;
      err_max      <= '0;
    end else if (!stall) begin
      s1_valid_reg <= issue;
      if (issue) begin
        s1_a_reg     <= pair_cnt_reg[2*W-1:W];
        s1_b_reg     <= pair_cnt_reg[W-1:0];
        pair_cnt_reg <= pair_cnt_reg + 1'b1;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_a_reg      <= s1_a_reg;
        s2_b_reg      <= s1_b_reg;
        s2_approx_reg <= mul_approx;
        s2_exact_reg  <= mul_exact;
      end
      if (s2_valid_reg) begin
        if (diff != '0) err_cnt <= err_cnt + CNT_W'(1);
        err_sum <= err_sum + SUM_W'(diff);
        if (diff > err_max) err_max <= diff;
      end
    end
  end

`ifdef APPROX_STREAM_EN
  logic           out_valid_reg;
  logic [W-1:0]   out_a_reg, out_b_reg;
  logic [2*W-1:0] out_approx_reg, out_exact_reg;

  assign stall = out_valid_reg && !res.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_a_reg      <= '0;
      out_b_reg      <= '0;
      out_approx_reg <= '0;
      out_exact_reg  <= '0;
    end else if (!stall) begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_a_reg      <= s2_a_reg;
        out_b_reg      <= s2_b_reg;
        out_approx_reg <= s2_approx_reg;
        out_exact_reg  <= s2_exact_reg;
      end
    end
  end

  assign res.res_valid  = out_valid_reg;
  assign res.res_a      = out_a_reg;
  assign res.res_b      = out_b_reg;
  assign res.res_approx = out_approx_reg;
  assign res.res_exact  = out_exact_reg;
`else
  logic unused_stream;

  assign stall          = 1'b0;
  assign res.res_valid  = 1'b0;
  assign res.res_a      = '0;
  assign res.res_b      = '0;
  assign res.res_approx = '0;
  assign res.res_exact  = '0;
  // Operands in stage 2 only feed the stream; res_ready is ignored here.
  assign unused_stream  = ^{res.res_ready, s2_a_reg, s2_b_reg};
`endif

endmodule

// File: tb/tb_approx_err_sweep.sv
// tb_approx_err_sweep: directed checks of approx_err_sweep at W=4, T=1.
// Stream-specific checks apply when APPROX_STREAM_EN is defined; otherwise
// the bench checks that the stream stays quiet and backpressure is ignored.
module tb_approx_err_sweep;
  import approx_pkg::*;

  localparam int W = 4;
  localparam int T = 1;
`ifdef APPROX_STREAM_EN
  localparam bit STREAM = 1'b1;
`else
  localparam bit STREAM = 1'b0;
`endif
  localparam int DONE_CYC = 259;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode  = 2'b00;
  logic           busy, done;
  logic [2*W:0]   err_cnt;
  logic [4*W-1:0] err_sum;
  logic [2*W-1:0] err_max;

  int  checks = 0;
  int  errors = 0;
  bit  seen_valid, found33, found22, stalled;

  approx_err_sweep_if #(.W(W)) res_if ();

  approx_err_sweep #(.W(W), .T(T)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .err_sum (err_sum),
    .err_max (err_max),
    .res     (res_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a sweep and waits for done; returns cycles from the start edge.
  // do_stall: drop res_ready for 10 cycles (at pair (5,7) when streaming).
  // disturb : re-pulse start and flip mode mid-sweep, then pulse start in DONE.
  task automatic run_sweep(input string name, input logic [1:0] m, input bit do_stall,
                           input bit disturb, output int cycles);
    bit timeout;
    seen_valid = 0; found33 = 0; found22 = 0; stalled = 0;
    @(negedge clk); start = 1'b1; mode = m;
    @(posedge clk); cycles = 0;
    @(negedge clk); start = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); cycles++;
      @(negedge clk);
      if (disturb && cycles == 30) begin start = 1'b1; mode = ~m; end
      if (disturb && cycles == 31) start = 1'b0;
      if (res_if.res_valid) seen_valid = 1;
      if (STREAM && m == 2'b10 && res_if.res_valid && res_if.res_a == 4'd3 && res_if.res_b == 4'd3) begin
        found33 = 1;
        check_val("pair33", {res_if.res_approx, res_if.res_exact}, {8'd4, 8'd9});
      end
      if (STREAM && m == 2'b10 && res_if.res_valid && res_if.res_a == 4'd2 && res_if.res_b == 4'd2) begin
        found22 = 1;
        check_val("pair22", {res_if.res_approx, res_if.res_exact}, {8'd4, 8'd4});
      end
      if (do_stall && !stalled && (STREAM ? (res_if.res_valid && res_if.res_a == 4'd5 && res_if.res_b == 4'd7)
                                          : (cycles == 100))) begin
        stalled = 1;
        res_if.res_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); cycles++;
          @(negedge clk);
          if (STREAM)
            check_val("stall_hold", {res_if.res_valid, res_if.res_a, res_if.res_b, res_if.res_approx, res_if.res_exact},
                      {1'b1, 4'd5, 4'd7, 8'd28, 8'd35});
        end
        res_if.res_ready = 1'b1;
      end
      if (done) begin timeout = 1'b0; break; end
    end
    check_val({name, "_timeout"}, 64'(timeout), 64'd0);
    $display("sweep %s mode=%0d cycles=%0d cnt=%0d sum=%0d max=%0d", name, m, cycles, err_cnt, err_sum, err_max);
    if (disturb) begin
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_val("start_in_done_ignored", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int cyc;
    res_if.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", {err_cnt, err_sum, err_max}, 64'd0);
    check_val("rst_res", {res_if.res_valid, res_if.res_a, res_if.res_b, res_if.res_approx, res_if.res_exact}, 64'd0);
    rst_n = 1'b1;

    run_sweep("exact00", 2'b00, 0, 0, cyc);
    check_val("exact00_cycles", 64'(cyc), 64'(DONE_CYC));
    check_val("exact00_cnt", 64'(err_cnt), 64'd0);
    check_val("exact00_sum", 64'(err_sum), 64'd0);
    check_val("exact00_max", 64'(err_max), 64'd0);
    check_val("exact00_stream_seen", 64'(seen_valid), 64'(STREAM));

    run_sweep("trunc_a", 2'b01, 0, 0, cyc);
    check_val("trunc_a_cycles", 64'(cyc), 64'(DONE_CYC));
    check_val("trunc_a_cnt", 64'(err_cnt), 64'd120);
    check_val("trunc_a_sum", 64'(err_sum), 64'd960);
    check_val("trunc_a_max", 64'(err_max), 64'd15);
    repeat (5) @(negedge clk);
    check_val("trunc_a_held", {err_cnt, err_sum, err_max}, {9'd120, 16'd960, 8'd15});

    run_sweep("trunc_ab", 2'b10, 0, 0, cyc);
    check_val("trunc_ab_cycles", 64'(cyc), 64'(DONE_CYC));
    check_val("trunc_ab_cnt", 64'(err_cnt), 64'd176);
    check_val("trunc_ab_sum", 64'(err_sum), 64'd1856);
    check_val("trunc_ab_max", 64'(err_max), 64'd29);
    check_val("trunc_ab_found", {63'd0, found33 & found22}, 64'(STREAM));

    run_sweep("exact11", 2'b11, 0, 0, cyc);
    check_val("exact11_cycles", 64'(cyc), 64'(DONE_CYC));
    check_val("exact11_err", {err_cnt, err_sum, err_max}, 64'd0);

    run_sweep("stall", 2'b01, 1, 0, cyc);
    check_val("stall_cycles", 64'(cyc), 64'(STREAM ? DONE_CYC + 10 : DONE_CYC));
    check_val("stall_totals", {err_cnt, err_sum, err_max}, {9'd120, 16'd960, 8'd15});
    check_val("stall_stalled", 64'(stalled), 64'd1);

    // Abort a sweep with reset part-way through.
    @(negedge clk); start = 1'b1; mode = 2'b01;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    check_val("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_ctrl", {busy, done}, 64'd0);
    check_val("abort_err", {err_cnt, err_sum, err_max}, 64'd0);
    check_val("abort_res", {res_if.res_valid, res_if.res_a, res_if.res_b, res_if.res_approx, res_if.res_exact}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    $display("reset abort applied mid-sweep");

    run_sweep("after_rst", 2'b01, 0, 0, cyc);
    check_val("after_rst_cycles", 64'(cyc), 64'(DONE_CYC));
    check_val("after_rst_totals", {err_cnt, err_sum, err_max}, {9'd120, 16'd960, 8'd15});

    run_sweep("disturb", 2'b01, 0, 1, cyc);
    check_val("disturb_cycles", 64'(cyc), 64'(DONE_CYC));
    check_val("disturb_totals", {err_cnt, err_sum, err_max}, {9'd120, 16'd960, 8'd15});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
